// File: rtl/dog_extrema_detect_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dog_extrema_detect_pkg                                        |
// | Purpose  : Shared widths, frame geometry and types for the DoG extrema   |
// |            detector and its line buffers. Frame geometry matches the     |
// |            Gaussian blur stages that feed this block.                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package dog_extrema_detect_pkg;

  localparam int IMG_WIDTH  = 400;
  localparam int IMG_HEIGHT = 300;
  localparam int PIX_W      = 8;
  localparam int DOG_W      = 9;
  localparam int COORD_W    = 9;

  typedef logic signed [DOG_W-1:0] dog_t;
  typedef logic [COORD_W-1:0]      coord_t;

  // One keypoint record as held in the output register.
  typedef struct packed {
    logic   valid;
    coord_t x;
    coord_t y;
    dog_t   dog;
    logic   is_max;
  } kp_rec_t;

  // Difference of two unsigned pixels as a 9-bit two's-complement value.
  // The range is -255..+255, so no saturation is ever needed.
  function automatic dog_t dog_sub(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

endpackage : dog_extrema_detect_pkg
`default_nettype wire

// File: rtl/dog_line_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dog_line_buffer                                               |
// | Purpose  : DEPTH-stage shift register that delays a DoG sample by one    |
// |            image line of accepted pixels.                                |
// | Ports    : clk  - clock                                                  |
// |            ce   - shift enable (pixel strobe)                            |
// |            sclr - synchronous clear of every stage                       |
// |            d    - sample in                                              |
// |            q    - sample pushed DEPTH enabled cycles earlier             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module dog_line_buffer #(
  parameter int DEPTH = 400,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         ce,
  input  logic         sclr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (sclr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else if (ce) begin
      stage_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule : dog_line_buffer
`default_nettype wire

// File: rtl/dog_extrema_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dog_extrema_detect                                            |
// | Purpose  : Forms the Difference-of-Gaussian of two aligned blurred       |
// |            streams, keeps a 3x3 DoG window over two line buffers and     |
// |            reports every interior strict local max/min whose magnitude   |
// |            reaches THRESH as a one-cycle keypoint record.                |
// | Ports    : clk, rst           - clock, synchronous active-high reset     |
// |            clk_en             - pixel strobe, g_a/g_b valid              |
// |            g_a, g_b           - blurred pixels, finer / coarser scale    |
// |            kp_valid           - keypoint record valid (1 cycle)          |
// |            kp_x, kp_y         - keypoint column / row                    |
// |            kp_dog, kp_is_max  - DoG value, 1 = maximum / 0 = minimum     |
// |            frame_done         - pulse after last pixel of a frame        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module dog_extrema_detect
  import dog_extrema_detect_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int THRESH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic [PIX_W-1:0]        g_a,
  input  logic [PIX_W-1:0]        g_b,
  output logic                    kp_valid,
  output logic [COORD_W-1:0]      kp_x,
  output logic [COORD_W-1:0]      kp_y,
  output logic signed [DOG_W-1:0] kp_dog,
  output logic                    kp_is_max,
  output logic                    frame_done
);

  localparam coord_t X_LAST  = coord_t'(WIDTH - 1);
  localparam coord_t Y_LAST  = coord_t'(HEIGHT - 1);
  localparam dog_t   THR_POS = dog_t'(THRESH);
  localparam dog_t   THR_NEG = dog_t'(-THRESH);

  // ---------------------------------------------------------------- counters
  coord_t x_q, x_d;
  coord_t y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clk_en) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + coord_t'(1);
      end else begin
        x_d = x_q + coord_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // ------------------------------------------------------ DoG + line buffers
  dog_t dog_cur;   // row y
  dog_t row1_cur;  // row y-1, same column
  dog_t row2_cur;  // row y-2, same column

  assign dog_cur = dog_sub(g_a, g_b);

  dog_line_buffer #(.DEPTH(WIDTH), .W(DOG_W)) u_lb1 (
    .clk  (clk),
    .ce   (clk_en),
    .sclr (rst),
    .d    (dog_cur),
    .q    (row1_cur)
  );

  dog_line_buffer #(.DEPTH(WIDTH), .W(DOG_W)) u_lb2 (
    .clk  (clk),
    .ce   (clk_en),
    .sclr (rst),
    .d    (row1_cur),
    .q    (row2_cur)
  );

  // ------------------------------------------------------------------ window
  // Index 0 = top row (y-2), 1 = middle (y-1), 2 = bottom (y).
  // col_cur is column x, col1_q is x-1 (holds the centre), col0_q is x-2.
  dog_t col_cur [3];
  dog_t col1_q  [3];
  dog_t col0_q  [3];

  always_comb begin
    col_cur[0] = row2_cur;
    col_cur[1] = row1_cur;
    col_cur[2] = dog_cur;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        col0_q[i] <= '0;
        col1_q[i] <= '0;
      end
    end else if (clk_en) begin
      for (int i = 0; i < 3; i++) begin
        col0_q[i] <= col1_q[i];
        col1_q[i] <= col_cur[i];
      end
    end
  end

  // ------------------------------------------------------------ compare tree
  dog_t centre;
  dog_t nb [8];
  logic all_gt;
  logic all_lt;
  logic eval_en;
  logic hit_max;
  logic hit_min;

  assign centre = col1_q[1];

  always_comb begin
    nb[0] = col0_q[0];
    nb[1] = col0_q[1];
    nb[2] = col0_q[2];
    nb[3] = col1_q[0];
    nb[4] = col1_q[2];
    nb[5] = col_cur[0];
    nb[6] = col_cur[1];
    nb[7] = col_cur[2];
  end

  // Strict compares: any neighbour equal to the centre (plateau) clears both.
  always_comb begin
    all_gt = 1'b1;
    all_lt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!(centre > nb[i])) all_gt = 1'b0;
      if (!(centre < nb[i])) all_lt = 1'b0;
    end
  end

  // x>=2 && y>=2 keeps the centre off every border and stops a window from
  // straddling a line wrap; after reset it also guarantees both line buffers
  // hold only post-reset rows before anything is evaluated.
  assign eval_en = clk_en && (x_q >= coord_t'(2)) && (y_q >= coord_t'(2));
  assign hit_max = eval_en && all_gt && (centre >= THR_POS);
  assign hit_min = eval_en && all_lt && (centre <= THR_NEG);

  // --------------------------------------------------------- output register
  kp_rec_t kp_q, kp_d;
  logic    frame_done_q, frame_done_d;

  always_comb begin
    kp_d       = kp_q;
    kp_d.valid = hit_max || hit_min;
    if (hit_max || hit_min) begin
      kp_d.x      = x_q - coord_t'(1);
      kp_d.y      = y_q - coord_t'(1);
      kp_d.dog    = centre;
      kp_d.is_max = hit_max;
    end
    frame_done_d = clk_en && (x_q == X_LAST) && (y_q == Y_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kp_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      kp_q         <= kp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign kp_valid   = kp_q.valid;
  assign kp_x       = kp_q.x;
  assign kp_y       = kp_q.y;
  assign kp_dog     = kp_q.dog;
  assign kp_is_max  = kp_q.is_max;
  assign frame_done = frame_done_q;

endmodule : dog_extrema_detect
`default_nettype wire

// File: tb/tb_dog_extrema_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dog_extrema_detect                                         |
// | Purpose  : Self-checking bench for dog_extrema_detect on a reduced       |
// |            16x10 frame, with a frame-level reference model.              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dog_extrema_detect;

  localparam int W   = 16;
  localparam int H   = 10;
  localparam int THR = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_en;
  logic [7:0]        g_a;
  logic [7:0]        g_b;
  logic              kp_valid;
  logic [8:0]        kp_x;
  logic [8:0]        kp_y;
  logic signed [8:0] kp_dog;
  logic              kp_is_max;
  logic              frame_done;

  always #5 clk = ~clk;

  dog_extrema_detect #(.WIDTH(W), .HEIGHT(H), .THRESH(THR)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .g_a        (g_a),
    .g_b        (g_b),
    .kp_valid   (kp_valid),
    .kp_x       (kp_x),
    .kp_y       (kp_y),
    .kp_dog     (kp_dog),
    .kp_is_max  (kp_is_max),
    .frame_done (frame_done)
  );

  // Frame content currently being streamed.
  int ga [H][W];
  int gb [H][W];
  int cur_x = 0;
  int cur_y = 0;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  typedef struct {
    bit v;
    int x;
    int y;
    int dog;
    bit mx;
    bit fd;
  } exp_t;

  typedef struct {
    int x;
    int y;
    int dog;
    bit mx;
  } rec_t;

  exp_t e = '{default: 0};
  rec_t kp_log [$];
  rec_t saved  [$];
  int   fd_log [$];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Keypoint test straight from the frame arrays: strict 3x3 extremum with
  // |DoG| >= THR, signed arithmetic on plain integers.
  function automatic bit kp_at(input int cx, input int cy, output int dog, output bit mx);
    int  c;
    int  n;
    bit  gt;
    bit  lt;
    c  = ga[cy][cx] - gb[cy][cx];
    gt = 1'b1;
    lt = 1'b1;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (dx != 0 || dy != 0) begin
          n = ga[cy+dy][cx+dx] - gb[cy+dy][cx+dx];
          if (!(c > n)) gt = 1'b0;
          if (!(c < n)) lt = 1'b0;
        end
      end
    end
    dog = c;
    mx  = gt && (c >= THR);
    return (gt && (c >= THR)) || (lt && (c <= -THR));
  endfunction

  // Output expected after an edge, given what was presented before it.
  function automatic exp_t next_exp(input exp_t prev, input logic r, input logic en,
                                    input int px, input int py);
    exp_t nx;
    int   dv;
    bit   m;
    nx    = prev;
    nx.v  = 1'b0;
    nx.fd = 1'b0;
    if (r) begin
      nx = '{default: 0};
    end else if (en) begin
      nx.fd = (px == W-1) && (py == H-1);
      if (px >= 2 && py >= 2) begin
        if (kp_at(px-1, py-1, dv, m)) begin
          nx.v   = 1'b1;
          nx.x   = px - 1;
          nx.y   = py - 1;
          nx.dog = dv;
          nx.mx  = m;
        end
      end
    end
    return nx;
  endfunction

  always @(posedge clk) e <= next_exp(e, rst, clk_en, cur_x, cur_y);

  always @(negedge clk) begin
    if (chk_on) begin
      check("kp_valid",   kp_valid,        e.v);
      check("kp_x",       kp_x,            e.x);
      check("kp_y",       kp_y,            e.y);
      check("kp_dog",     kp_dog,          e.dog);
      check("kp_is_max",  kp_is_max,       e.mx);
      check("frame_done", frame_done,      e.fd);
      if (kp_valid === 1'b1)
        kp_log.push_back('{int'(kp_x), int'(kp_y), int'(kp_dog), kp_is_max});
      if (frame_done === 1'b1) fd_log.push_back(1);
    end
  end

  task automatic fill(input int a, input int b);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        ga[y][x] = a;
        gb[y][x] = b;
      end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      clk_en = 1'b0;
      g_a    = 8'($urandom);
      g_b    = 8'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Streams one frame in raster order; gap_max>0 inserts random idle cycles.
  // When (rx,ry) is reached a one-cycle reset is applied instead and the
  // frame is abandoned.
  task automatic drive_frame(input int gap_max, input int rx, input int ry);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
        if (x == rx && y == ry) begin
          rst    = 1'b1;
          clk_en = 1'b1;
          g_a    = 8'($urandom);
          g_b    = 8'($urandom);
          @(posedge clk); #1;
          rst    = 1'b0;
          clk_en = 1'b0;
          cur_x  = 0;
          cur_y  = 0;
          check("rst_kp_valid",   kp_valid,   0);
          check("rst_kp_x",       kp_x,       0);
          check("rst_kp_y",       kp_y,       0);
          check("rst_kp_dog",     kp_dog,     0);
          check("rst_kp_is_max",  kp_is_max,  0);
          check("rst_frame_done", frame_done, 0);
          return;
        end
        cur_x  = x;
        cur_y  = y;
        clk_en = 1'b1;
        g_a    = 8'(ga[y][x]);
        g_b    = 8'(gb[y][x]);
        @(posedge clk); #1;
      end
    end
    clk_en = 1'b0;
  endtask

  task automatic clear_logs();
    kp_log.delete();
    fd_log.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clk_en = 1'b0; g_a = 8'd0; g_b = 8'd0;
    fill(0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_kp_valid",   kp_valid,   0);
    check("reset_kp_x",       kp_x,       0);
    check("reset_kp_dog",     kp_dog,     0);
    check("reset_frame_done", frame_done, 0);
    rst    = 1'b0;
    chk_on = 1'b1;

    // Flat frames: no keypoints, one frame_done per frame.
    fill(100, 100); clear_logs();
    drive_frame(0, -1, -1);
    drive_frame(0, -1, -1);
    idle(4);
    check("t1_kp_count", kp_log.size(), 0);
    check("t1_fd_count", fd_log.size(), 2);

    // Single positive spot -> one maximum.
    fill(40, 40); ga[4][5] = 60; clear_logs();
    drive_frame(0, -1, -1); idle(4);
    check("t2_kp_count", kp_log.size(), 1);
    check("t2_fd_count", fd_log.size(), 1);
    if (kp_log.size() > 0) begin
      check("t2_x",   kp_log[0].x,   5);
      check("t2_y",   kp_log[0].y,   4);
      check("t2_dog", kp_log[0].dog, 20);
      check("t2_max", kp_log[0].mx,  1);
    end

    // Single negative spot -> one minimum.
    fill(40, 40); gb[6][9] = 90; clear_logs();
    drive_frame(0, -1, -1); idle(4);
    check("t3_kp_count", kp_log.size(), 1);
    if (kp_log.size() > 0) begin
      check("t3_x",   kp_log[0].x,   9);
      check("t3_y",   kp_log[0].y,   6);
      check("t3_dog", kp_log[0].dog, -50);
      check("t3_max", kp_log[0].mx,  0);
    end

    // Below threshold and plateau pair.
    fill(40, 40); ga[3][3] = 42; ga[5][10] = 60; ga[5][11] = 60; clear_logs();
    drive_frame(0, -1, -1); idle(4);
    check("t4_kp_count", kp_log.size(), 0);

    // Border spots, gap-free and with random gaps.
    fill(40, 40); ga[5][0] = 60; ga[5][W-1] = 60; ga[0][7] = 60; ga[H-1][7] = 60;
    clear_logs();
    drive_frame(0, -1, -1); idle(4);
    check("t5_kp_count", kp_log.size(), 0);
    clear_logs();
    drive_frame(5, -1, -1); idle(4);
    check("t5_gap_kp_count", kp_log.size(), 0);
    check("t5_gap_fd_count", fd_log.size(), 1);

    // Borders plus one interior max and one interior min, replayed with gaps.
    ga[4][8] = 60; gb[7][3] = 80;
    clear_logs();
    drive_frame(0, -1, -1); idle(4);
    check("t5b_kp_count", kp_log.size(), 2);
    if (kp_log.size() == 2) begin
      check("t5b_first_x",   kp_log[0].x,   8);
      check("t5b_first_y",   kp_log[0].y,   4);
      check("t5b_second_x",  kp_log[1].x,   3);
      check("t5b_second_dog", kp_log[1].dog, -40);
    end
    saved = kp_log;
    clear_logs();
    drive_frame(5, -1, -1); idle(4);
    check("t5b_gap_kp_count", kp_log.size(), saved.size());
    for (int i = 0; i < kp_log.size() && i < saved.size(); i++) begin
      check("t5b_gap_x",   kp_log[i].x,   saved[i].x);
      check("t5b_gap_y",   kp_log[i].y,   saved[i].y);
      check("t5b_gap_dog", kp_log[i].dog, saved[i].dog);
      check("t5b_gap_max", kp_log[i].mx,  saved[i].mx);
    end

    // Reset mid-frame, then a fresh frame with the single spot.
    fill(40, 40); ga[4][5] = 60; clear_logs();
    drive_frame(0, 12, 6);
    check("t6_pre_rst_kp_count", kp_log.size(), 1);
    clear_logs();
    drive_frame(0, -1, -1); idle(4);
    check("t6_kp_count", kp_log.size(), 1);
    check("t6_fd_count", fd_log.size(), 1);
    if (kp_log.size() > 0) begin
      check("t6_x",   kp_log[0].x,   5);
      check("t6_y",   kp_log[0].y,   4);
      check("t6_dog", kp_log[0].dog, 20);
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_dog_extrema_detect
`default_nettype wire
